// File: rtl/spi_cmd_decoder.sv
// Frame parser behind the SPI slave byte receiver: turns command/address/data
// byte streams into phase-register writes, commit pulses and the drive enable.
module spi_cmd_decoder #(
    parameter int NUM_CH  = 64,
    parameter int ADDR_W  = 6,
    parameter int PHASE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ss,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PHASE_W-1:0] wr_data,
    output logic               commit,
    output logic               out_en,
    output logic               err,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR    = 3'd2,
        DATA    = 3'd3,
        EN      = 3'd4,
        DISCARD = 3'd5
    } state_t;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_COMMIT = 8'h02;
    localparam logic [7:0] CMD_ENABLE = 8'h03;

    // 9 bits so that NUM_CH = 256 still compares correctly against a byte
    localparam logic [8:0]        NUM_CH_W  = 9'(NUM_CH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CH - 1);

    state_t             state, state_n;
    logic               ss_armed, ss_armed_n;
    logic               ovf_pend, ovf_pend_n;
    logic [ADDR_W-1:0]  addr_reg, addr_reg_n;
    logic               wr_en_n, commit_n, err_n, out_en_n;
    logic [ADDR_W-1:0]  wr_addr_n;
    logic [PHASE_W-1:0] wr_data_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ss_armed <= 1'b0;
            ovf_pend <= 1'b0;
            addr_reg <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            commit   <= 1'b0;
            out_en   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            ss_armed <= ss_armed_n;
            ovf_pend <= ovf_pend_n;
            addr_reg <= addr_reg_n;
            wr_en    <= wr_en_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            commit   <= commit_n;
            out_en   <= out_en_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        ss_armed_n = ss_armed;
        ovf_pend_n = ovf_pend;
        addr_reg_n = addr_reg;
        wr_en_n    = 1'b0;
        commit_n   = 1'b0;
        err_n      = 1'b0;
        out_en_n   = out_en;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;

        case (state)
            IDLE: begin
                // A frame only opens on a seen high-to-low chip-select edge
                if (ss) begin
                    ss_armed_n = 1'b1;
                end else if (ss_armed) begin
                    ss_armed_n = 1'b0;
                    state_n    = CMD;
                end
            end
            CMD: begin
                if (byte_valid) begin
                    case (byte_in)
                        CMD_WRITE:  state_n = ADDR;
                        CMD_COMMIT: begin
                            commit_n = 1'b1;
                            state_n  = DISCARD;
                        end
                        CMD_ENABLE: state_n = EN;
                        default: begin
                            err_n   = 1'b1;
                            state_n = DISCARD;
                        end
                    endcase
                end
            end
            ADDR: begin
                if (byte_valid) begin
                    if ({1'b0, byte_in} >= NUM_CH_W) begin
                        err_n   = 1'b1;
                        state_n = DISCARD;
                    end else begin
                        addr_reg_n = byte_in[ADDR_W-1:0];
                        state_n    = DATA;
                    end
                end
            end
            DATA: begin
                if (byte_valid) begin
                    wr_en_n    = 1'b1;
                    wr_addr_n  = addr_reg;
                    wr_data_n  = byte_in[PHASE_W-1:0];
                    addr_reg_n = addr_reg + ADDR_W'(1);
                    // Last channel written: the next byte is an overflow, not a wrap
                    if (addr_reg == LAST_ADDR) begin
                        ovf_pend_n = 1'b1;
                        state_n    = DISCARD;
                    end
                end
            end
            EN: begin
                if (byte_valid) begin
                    out_en_n = byte_in[0];
                    state_n  = DISCARD;
                end
            end
            DISCARD: begin
                if (byte_valid && ovf_pend) begin
                    err_n      = 1'b1;
                    ovf_pend_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Chip select high ends any frame; a byte in the same cycle still counts
        if (state != IDLE && ss) begin
            state_n    = IDLE;
            ss_armed_n = 1'b1;
            ovf_pend_n = 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: pulses are scoreboarded against an
// expected queue tagged with the cycle each pulse is due.
module tb_spi_cmd_decoder;

    localparam int NUM_CH  = 64;
    localparam int ADDR_W  = 6;
    localparam int PHASE_W = 8;
    localparam int W       = 16;

    // event encoding: {kind[1:0], addr[5:0], data[7:0]}
    localparam logic [1:0] EV_WR  = 2'd1;
    localparam logic [1:0] EV_CMT = 2'd2;
    localparam logic [1:0] EV_ERR = 2'd3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ss = 1'b1;
    logic               byte_valid = 1'b0;
    logic [7:0]         byte_in = 8'h00;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PHASE_W-1:0] wr_data;
    logic               commit;
    logic               out_en;
    logic               err;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    int           due_q[$];

    spi_cmd_decoder #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W)) dut (
        .clk(clk), .rst(rst), .ss(ss), .byte_valid(byte_valid), .byte_in(byte_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .out_en(out_en), .err(err), .busy(busy)
    );

    // clock / cycle counter
    always #10 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ev_wr(input int a, input int d);
        logic [5:0] a6;
        logic [7:0] d8;
        a6 = 6'(a);
        d8 = 8'(d);
        return {EV_WR, a6, d8};
    endfunction

    // scoreboard monitor: every pulse must match the queue head on its due cycle
    always @(negedge clk) begin
        logic [W-1:0] obs;
        logic [W-1:0] e;
        int d;
        if (wr_en || commit || err) begin
            check("no_overlap", 32'(wr_en) + 32'(commit) + 32'(err), 32'd1);
            obs = wr_en ? {EV_WR, wr_addr, wr_data} : (commit ? {EV_CMT, 14'd0} : {EV_ERR, 14'd0});
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(obs), 32'd0);
            end else begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("pulse_value", 32'(obs), 32'(e));
                check("pulse_latency", cyc, d);
            end
        end
        if (due_q.size() != 0 && due_q[0] < cyc) begin
            check("missing_pulse", 32'd0, 32'(exp_q[0]));
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input logic has_ev, input logic [W-1:0] ev);
        byte_valid = 1'b1;
        byte_in    = b;
        if (has_ev) begin
            exp_q.push_back(ev);
            due_q.push_back(cyc + 1);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = 8'($urandom_range(0, 255));
    endtask

    task automatic frame_start();
        ss = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        ss = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // reset held 10 cycles with ss high
        idle_cycles(10);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_commit", 32'(commit), 0);
        check("rst_out_en", 32'(out_en), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // burst write from channel 5
        frame_start();
        check("busy_in_frame", 32'(busy), 1);
        send_byte(8'h01, 1'b0, '0);
        send_byte(8'h05, 1'b0, '0);
        send_byte(8'h10, 1'b1, ev_wr(5, 8'h10));
        send_byte(8'h20, 1'b1, ev_wr(6, 8'h20));
        send_byte(8'h30, 1'b1, ev_wr(7, 8'h30));
        check("busy_before_ss_high", 32'(busy), 1);
        ss = 1'b1;
        @(negedge clk);
        check("busy_after_ss_high", 32'(busy), 0);
        @(negedge clk);

        // commit, enable on, enable off
        frame_start();
        send_byte(8'h02, 1'b1, {EV_CMT, 14'd0});
        send_byte(8'h55, 1'b0, '0);
        frame_end();
        frame_start();
        send_byte(8'h03, 1'b0, '0);
        send_byte(8'h01, 1'b0, '0);
        check("out_en_set", 32'(out_en), 1);
        frame_end();
        check("out_en_hold", 32'(out_en), 1);
        frame_start();
        send_byte(8'h03, 1'b0, '0);
        send_byte(8'hFE, 1'b0, '0);
        check("out_en_clear", 32'(out_en), 0);
        frame_end();

        // bad command, then out-of-range address
        frame_start();
        send_byte(8'h7F, 1'b1, {EV_ERR, 14'd0});
        send_byte(8'h01, 1'b0, '0);
        send_byte(8'h00, 1'b0, '0);
        send_byte(8'h99, 1'b0, '0);
        frame_end();
        frame_start();
        send_byte(8'h01, 1'b0, '0);
        send_byte(8'h40, 1'b1, {EV_ERR, 14'd0});
        send_byte(8'h12, 1'b0, '0);
        frame_end();

        // last-channel overflow: two writes, one err, then silence
        frame_start();
        send_byte(8'h01, 1'b0, '0);
        send_byte(8'h3E, 1'b0, '0);
        send_byte(8'hAA, 1'b1, ev_wr(62, 8'hAA));
        send_byte(8'hBB, 1'b1, ev_wr(63, 8'hBB));
        send_byte(8'hCC, 1'b1, {EV_ERR, 14'd0});
        send_byte(8'hDD, 1'b0, '0);
        frame_end();

        // byte and ss rising in the same cycle
        frame_start();
        send_byte(8'h01, 1'b0, '0);
        send_byte(8'h00, 1'b0, '0);
        ss = 1'b1;
        send_byte(8'h11, 1'b1, ev_wr(0, 8'h11));
        check("idle_after_same_cycle_ss", 32'(busy), 0);
        @(negedge clk);
        frame_start();
        send_byte(8'h01, 1'b0, '0);
        send_byte(8'h09, 1'b0, '0);
        send_byte(8'h42, 1'b1, ev_wr(9, 8'h42));
        frame_end();

        // reset mid-DATA with drive enabled and ss held low
        frame_start();
        send_byte(8'h03, 1'b0, '0);
        send_byte(8'h01, 1'b0, '0);
        frame_end();
        frame_start();
        send_byte(8'h01, 1'b0, '0);
        send_byte(8'h20, 1'b0, '0);
        check("out_en_before_rst", 32'(out_en), 1);
        rst = 1'b1;
        idle_cycles(2);
        check("midrst_out_en", 32'(out_en), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_wr_addr", 32'(wr_addr), 0);
        check("midrst_wr_data", 32'(wr_data), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send_byte((i == 0) ? 8'h01 : 8'($urandom_range(0, 63)), 1'b0, '0);
        end
        check("no_frame_without_ss_edge", 32'(busy), 0);
        ss = 1'b1;
        idle_cycles(2);
        frame_start();
        send_byte(8'h01, 1'b0, '0);
        send_byte(8'h02, 1'b0, '0);
        send_byte(8'h77, 1'b1, ev_wr(2, 8'h77));
        frame_end();

        idle_cycles(4);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI slave byte receiver, in the 50 MHz FPGA clock domain.
- Consumes the receiver's one-cycle byte strobe and byte value, framed by chip select.
- Parses frames into transducer phase-register writes, a commit (latch) pulse, and an output-enable setting.
- Feeds the phase register bank and the phase-generator latch.

Parameters:
NUM_CH, 64, number of transducer channels; legal addresses are 0..NUM_CH-1
ADDR_W, 6, width of wr_addr; must satisfy 2^ADDR_W >= NUM_CH
PHASE_W, 8, width of wr_data; must be <= 8; taken from byte_in[PHASE_W-1:0]

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset, synchronous, active-high
ss  in  1  chip select, active-low, already synchronized to clk; low = frame active
byte_valid  in  1  one-cycle strobe from the SPI receiver's done output; byte_in is valid in this cycle
byte_in  in  8  received byte, connected to the receiver's dout
wr_en  out  1  one-cycle phase-register write strobe
wr_addr  out  ADDR_W  channel address for the write
wr_data  out  PHASE_W  phase value for the write
commit  out  1  one-cycle pulse; latches the phase bank into the generator
out_en  out  1  level; transducer drive enable
err  out  1  one-cycle pulse on a protocol error
busy  out  1  high while a frame is being parsed (state != IDLE)

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, commit=0, out_en=0, err=0, busy=0, state=IDLE, ss_armed=0, addr_reg=0.
- All outputs are registered. Latency is 1 clk from a byte_valid cycle to the resulting wr_en, commit or err pulse, or to the out_en change.
- Frame start: a new frame needs ss to be seen high, then low.
  - ss_armed is set while ss=1 in IDLE.
  - IDLE -> CMD only when ss=0 and ss_armed=1. This clears ss_armed.
  - After reset with ss already low, the block stays in IDLE until ss goes high and low again.
- byte_valid in IDLE is ignored.
- CMD, on byte_valid:
  - 0x01 -> ADDR.
  - 0x02 -> commit pulse, then DISCARD.
  - 0x03 -> EN.
  - Any other value -> err pulse, then DISCARD.
- ADDR, on byte_valid:
  - byte_in >= NUM_CH -> err pulse, then DISCARD.
  - Otherwise addr_reg <= byte_in[ADDR_W-1:0], then DATA.
- DATA, on each byte_valid:
  - Next cycle: wr_en=1, wr_addr=addr_reg, wr_data=byte_in[PHASE_W-1:0].
  - addr_reg increments.
  - If the written address was NUM_CH-1, go to DISCARD. The next byte in the frame then raises one err pulse; no wrap-around and no write occur.
- EN, on byte_valid: out_en <= byte_in[0], then DISCARD.
- DISCARD:
  - Ignores bytes, except the single overflow err pulse described under DATA.
  - Remains until ss is high.
- ss=1 in any non-IDLE state: go to IDLE and set ss_armed.
  - A partial frame needs no cleanup: already-issued writes stand, no commit is generated, and an ADDR/EN state with no byte has no effect.
- Simultaneous byte_valid and ss=1 in the same cycle: the byte is processed normally, including its output pulse, then the state goes to IDLE.
- Back-to-back byte_valid on consecutive clk cycles must be accepted without loss.
- Reset mid-frame: all state and outputs go to their reset values. out_en drops to 0 (drive disabled).
- Pulses (wr_en, commit, err) are exactly one cycle wide and never overlap in the same cycle.

Test Plan:
- Reset held 10 cycles with ss=1, then released. Frame: ss low, bytes 0x01,0x05,0x10,0x20,0x30, ss high -> three wr_en pulses, (addr,data)=(5,0x10),(6,0x20),(7,0x30), each 1 clk after its byte_valid; busy falls on ss high.
- Frame 0x02 -> one commit pulse, 1 clk after byte_valid. Frame 0x03,0x01 -> out_en=1. Frame 0x03,0x00 -> out_en=0. No wr_en in either.
- Bad command 0x7F, then 0x01 in the same frame -> one err pulse, no writes. Next frame 0x01,0x40 (NUM_CH=64) -> err pulse, no writes.
- Overflow frame 0x01,0x3E,0xAA,0xBB,0xCC -> writes (62,0xAA),(63,0xBB), then one err pulse for 0xCC, no third write.
- Frame 0x01,0x00,0x11 with ss rising in the same cycle as the 0x11 byte_valid -> write (0,0x11) occurs, then state is IDLE. A new frame starts cleanly.
- Reset asserted mid-DATA with out_en=1 and ss held low -> all outputs 0. Bytes received before ss toggles high then low produce no writes.
